// File: rtl/fitness_sequencer.sv
// fitness_sequencer: exhaustively drives every input vector of a candidate
// circuit, waits a settle time, compares the sampled outputs against a target
// table and accumulates the per-bit match count as the fitness score.
// Optional first-mismatch logging is enabled by defining FITNESS_SEQ_FAIL_LOG_EN.
module fitness_sequencer #(
  parameter int unsigned N_IN          = 5,
  parameter int unsigned N_OUT         = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [N_IN-1:0]    stim,
  input  logic [N_OUT-1:0]   resp,
  input  logic [N_OUT-1:0]   exp_resp,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic               first_fail_valid,
  output logic [N_IN-1:0]    first_fail_vec
);

  localparam int unsigned CW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned MW      = $clog2(N_OUT + 1);
  localparam int unsigned PERFECT = (1 << N_IN) * N_OUT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [SCORE_W-1:0] acc;
  logic [MW-1:0]      match_cnt_c;
  logic [SCORE_W-1:0] acc_next_c;

  // Number of output bits where the candidate agrees with the target
  always_comb begin
    match_cnt_c = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      match_cnt_c = match_cnt_c + MW'(~(resp[i] ^ exp_resp[i]));
    end
  end

  assign acc_next_c = acc + SCORE_W'(match_cnt_c);

  // Sequencer FSM with registered stim/busy/done/score/perfect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stim    <= '0;
      cnt     <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      score   <= '0;
      perfect <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          stim <= '0;
          busy <= 1'b0;
          if (start && !abort) begin
            state <= SETTLE;
            acc   <= '0;
            cnt   <= CW'(SETTLE_CYCLES - 1);
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            stim  <= '0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            stim  <= '0;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next_c;
            if (stim == '1) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              score   <= acc_next_c;
              perfect <= (acc_next_c == SCORE_W'(PERFECT));
            end else begin
              state <= SETTLE;
              stim  <= stim + N_IN'(1);
              cnt   <= CW'(SETTLE_CYCLES - 1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          stim  <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          stim  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FITNESS_SEQ_FAIL_LOG_EN
  logic            fail_seen;
  logic [N_IN-1:0] fail_vec;
  logic            mismatch_c;

  assign mismatch_c = (resp != exp_resp);

  // Capture the lowest mismatching vector of the run and publish it at completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen        <= 1'b0;
      fail_vec         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      if (state == IDLE && start && !abort) begin
        fail_seen <= 1'b0;
        fail_vec  <= '0;
      end else if (state == SAMPLE && !abort) begin
        if (mismatch_c && !fail_seen) begin
          fail_seen <= 1'b1;
          fail_vec  <= stim;
        end
        if (stim == '1) begin
          first_fail_valid <= fail_seen | mismatch_c;
          first_fail_vec   <= fail_seen ? fail_vec : (mismatch_c ? stim : '0);
        end
      end
    end
  end
`else
  assign first_fail_valid = 1'b0;
  assign first_fail_vec   = '0;
`endif

endmodule

// File: tb/tb_fitness_sequencer.sv
// Self-checking bench for fitness_sequencer: table-driven candidate with a
// gate-delay model, directed scenarios plus randomized tables scored by a
// truth-table reference model.
module tb_fitness_sequencer;

  localparam int unsigned N_IN    = 5;
  localparam int unsigned N_OUT   = 4;
  localparam int unsigned SC      = 4;
  localparam int unsigned SW      = 8;
  localparam int unsigned NV      = 1 << N_IN;
  localparam int unsigned RUN_CYC = NV * (SC + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N_IN-1:0]  stim;
  logic [N_OUT-1:0] resp;
  logic [N_OUT-1:0] exp_resp;
  logic             busy;
  logic             done;
  logic [SW-1:0]    score;
  logic             perfect;
  logic             ffv;
  logic [N_IN-1:0]  ffvec;

  logic [N_OUT-1:0] cand_tab [NV];
  logic [N_OUT-1:0] exp_tab  [NV];
  logic [N_IN-1:0]  stim_d = '0;

  int checks = 0;
  int errors = 0;

  fitness_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(SC), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stim(stim), .resp(resp), .exp_resp(exp_resp),
    .busy(busy), .done(done), .score(score), .perfect(perfect),
    .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  always #5 clk = ~clk;

  // Candidate gate delay: 7 ns, well below SETTLE_CYCLES * 10 ns
  always begin
    @(stim);
    #7;
    stim_d = stim;
  end

  assign resp     = cand_tab[stim_d];
  assign exp_resp = exp_tab[stim];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: score = matching bits over the whole truth table, first fail = lowest differing vector
  task automatic model(output int sc, output bit mffv, output int mfv);
    sc = 0; mffv = 1'b0; mfv = 0;
    for (int v = 0; v < int'(NV); v++) begin
      int d;
      d = $countones(cand_tab[v] ^ exp_tab[v]);
      sc += int'(N_OUT) - d;
      if (d != 0 && !mffv) begin
        mffv = 1'b1;
        mfv  = v;
      end
    end
  endtask

  task automatic run(input string tag, input int pulse_at);
    int  sc;
    bit  mffv;
    int  mfv;
    int  n;
    model(sc, mffv, mfv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_stim_start"}, 32'(stim), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      if (n == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(RUN_CYC));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'(sc));
    chk({tag, "_perfect"}, 32'(perfect), 32'(sc == int'(NV * N_OUT)));
`ifdef FITNESS_SEQ_FAIL_LOG_EN
    chk({tag, "_ffv"}, 32'(ffv), 32'(mffv));
    chk({tag, "_ffvec"}, 32'(ffvec), 32'(mffv ? mfv : 0));
`else
    chk({tag, "_ffv"}, 32'(ffv), 32'd0);
    chk({tag, "_ffvec"}, 32'(ffvec), 32'd0);
`endif
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_stim_idle"}, 32'(stim), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_stim(input int target, output bit ok);
    int n;
    n = 0;
    while (stim !== N_IN'(target) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (n < 300);
  endtask

  task automatic set_golden();
    for (int v = 0; v < int'(NV); v++) begin
      cand_tab[v] = N_OUT'($urandom);
      exp_tab[v]  = cand_tab[v];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    set_golden();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stim", 32'(stim), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Golden match
    run("golden", -1);
    chk("golden_const", 32'(score), 32'd128);

    // bit3 inverted everywhere
    for (int v = 0; v < int'(NV); v++) exp_tab[v] = cand_tab[v] ^ 4'h8;
    run("bit3", -1);
    chk("bit3_const", 32'(score), 32'd96);

    // Sparse bit0 mismatch at 13 and 27
    for (int v = 0; v < int'(NV); v++) exp_tab[v] = cand_tab[v];
    exp_tab[13] = exp_tab[13] ^ 4'h1;
    exp_tab[27] = exp_tab[27] ^ 4'h1;
    run("sparse", -1);
    chk("sparse_const", 32'(score), 32'd126);
`ifdef FITNESS_SEQ_FAIL_LOG_EN
    chk("sparse_ffvec_const", 32'(ffvec), 32'd13);
`endif

    // Golden with a stray start pulse mid-run
    set_golden();
    run("ign_start", 49);
    chk("ign_start_const", 32'(score), 32'd128);

    // Abort a mismatch run at stim=10 in SETTLE
    for (int v = 0; v < int'(NV); v++) exp_tab[v] = cand_tab[v] ^ 4'h8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_stim(10, ok);
    chk("abort_reach10", 32'(ok), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stim", 32'(stim), 32'd0);
    seen = 1'b0;
    repeat (200) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_score_hold", 32'(score), 32'd128);
    chk("abort_perfect_hold", 32'(perfect), 32'd1);
    chk("abort_ffv_hold", 32'(ffv), 32'd0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (busy !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("start_abort_idle", 32'(seen), 32'd0);

    // Randomized tables against the reference model
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < int'(NV); v++) begin
        cand_tab[v] = N_OUT'($urandom);
        exp_tab[v]  = cand_tab[v] ^ (($urandom_range(0, 3) == 0) ? N_OUT'($urandom) : N_OUT'(0));
      end
      run($sformatf("rand%0d", r), -1);
    end

    // Asynchronous reset mid-run
    set_golden();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_stim(20, ok);
    chk("rst_reach20", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_stim", 32'(stim), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_score", 32'(score), 32'd0);
    chk("mrst_perfect", 32'(perfect), 32'd0);
    chk("mrst_ffv", 32'(ffv), 32'd0);
    chk("mrst_ffvec", 32'(ffvec), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run("post_rst", -1);
    chk("post_rst_const", 32'(score), 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
